vae_reparam: RTL and testbench

- Streaming reparameterisation stage of the VAE latent path: z = mu + sigma * eps, with sigma = softplus(rho).
- softplus is piecewise: sigma = max(rho, 0) + offset(rho).
- offset(rho) comes from the external combinational offset lookup, driven through the sp_operand/sp_offset port pair.
- Sits between the encoder head (mu, rho) plus noise source (eps) and the decoder input. Elastic valid/ready handshake, 3-stage pipeline, per-vector last flag.

---
 rtl/vae_reparam.sv | 93 +++++++++
 tb/tb_vae_reparam.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vae_reparam.sv
// Reparameterisation stage z = mu + softplus(rho) * eps, Q8.8 fixed point.
// Three-stage global-stall pipeline with elastic valid/ready and a per-vector last flag.
module vae_reparam #(
  parameter int LATENT_DIM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_mu,
  input  logic [15:0] in_rho,
  input  logic [15:0] in_eps,
  output logic [15:0] sp_operand,
  input  logic [15:0] sp_offset,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_z,
  output logic        out_last
);

  localparam logic [15:0] LAST_IDX = 16'(LATENT_DIM - 1);

  logic        advance;
  logic [15:0] mu1, rho1, eps1;
  logic        v1;
  logic [15:0] sigma2, mu2, eps2;
  logic        v2;
  logic [15:0] cnt;

  logic [15:0]        relu;
  logic [16:0]        sig_sum;
  logic [15:0]        sigma_sat;
  logic signed [32:0] sig_ext, eps_ext, prod, prod_q;
  logic signed [33:0] sum;
  logic [15:0]        z_sat;

  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance;
  assign sp_operand = rho1;
  assign out_last   = out_valid && (cnt == LAST_IDX);

  always_comb begin
    relu      = rho1[15] ? 16'h0000 : rho1;
    sig_sum   = {1'b0, relu} + {1'b0, sp_offset};
    sigma_sat = (sig_sum > 17'h07FFF) ? 16'h7FFF : sig_sum[15:0];

    // sigma is non-negative, so it enters the multiply zero-extended
    sig_ext = $signed({17'b0, sigma2});
    eps_ext = $signed({{17{eps2[15]}}, eps2});
    prod    = sig_ext * eps_ext;
    prod_q  = (prod + 33'sd128) >>> 8;
    sum     = $signed({{18{mu2[15]}}, mu2}) + $signed({prod_q[32], prod_q});

    if (sum > 34'sh0_7FFF)
      z_sat = 16'h7FFF;
    else if (sum < -34'sh0_8000)
      z_sat = 16'h8000;
    else
      z_sat = sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mu1       <= '0;
      rho1      <= '0;
      eps1      <= '0;
      v1        <= 1'b0;
      sigma2    <= '0;
      mu2       <= '0;
      eps2      <= '0;
      v2        <= 1'b0;
      out_z     <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (advance) begin
        mu1       <= in_mu;
        rho1      <= in_rho;
        eps1      <= in_eps;
        v1        <= in_valid;
        sigma2    <= sigma_sat;
        mu2       <= mu1;
        eps2      <= eps1;
        v2        <= v1;
        out_z     <= z_sat;
        out_valid <= v2;
      end
      if (out_valid && out_ready)
        cnt <= (cnt == LAST_IDX) ? 16'h0000 : cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_vae_reparam.sv
// Directed bench for vae_reparam with a stepwise offset lookup attached to sp_operand/sp_offset.
module tb_vae_reparam;
  localparam int LD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mu, in_rho, in_eps;
  logic [15:0] sp_operand;
  logic [15:0] sp_offset;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic        out_last;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int lasts = 0;

  vae_reparam #(.LATENT_DIM(LD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mu(in_mu), .in_rho(in_rho), .in_eps(in_eps),
    .sp_operand(sp_operand), .sp_offset(sp_offset),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Coarse offset table keyed on |rho|
  function automatic logic [15:0] lookup(input logic [15:0] r);
    logic [16:0] a;
    a = r[15] ? (17'h10000 - {1'b0, r}) : {1'b0, r};
    if (a < 17'h00100)      return 16'h004D;
    else if (a < 17'h00300) return 16'h0037;
    else if (a < 17'h00800) return 16'h0020;
    else                    return 16'h0002;
  endfunction

  assign sp_offset = lookup(sp_operand);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [15:0] mu, input logic [15:0] rho,
                         input logic [15:0] eps, input logic [15:0] exp_z);
    in_valid = 1'b1; in_mu = mu; in_rho = rho; in_eps = eps;
    step();
    in_valid = 1'b0;
    check({tag, "_operand"}, 32'(sp_operand), 32'(rho));
    check({tag, "_v1"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_v2"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_v3"}, 32'(out_valid), 32'd1);
    check({tag, "_z"}, 32'(out_z), 32'(exp_z));
    step();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  // mode 0: out_ready low for cycles 6..10; mode 1: random out_ready
  task automatic stream(input int n, input logic [15:0] base, input int mode);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [15:0] held = '0;
    while (got < n && cyc < 300) begin
      in_valid = (sent < n);
      in_mu = base + 16'(sent); in_rho = 16'h0000; in_eps = 16'h0000;
      if (mode == 0) out_ready = !(cyc >= 6 && cyc < 11);
      else           out_ready = 1'($urandom_range(0, 1));
      #1;
      if (stalled) check("hold_z", 32'(out_z), 32'(held));
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        held = out_z;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("stream_z", 32'(out_z), 32'(base + 16'(got)));
        check("stream_last", 32'(out_last), 32'(exp_cnt == LD - 1));
        if (out_last) lasts++;
        exp_cnt = (exp_cnt == LD - 1) ? 0 : exp_cnt + 1;
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 32'(got), 32'(n));
    #1;
    check("stream_no_extra", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mu = '0; in_rho = '0; in_eps = '0; out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_z", 32'(out_z), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_operand", 32'(sp_operand), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    run_one("one", 16'h0000, 16'h0100, 16'h0100, 16'h0137);
    run_one("zero_rho", 16'h0100, 16'h0000, 16'h0200, 16'h019A);
    run_one("neg_rho", 16'h0000, 16'hFE00, 16'h0100, 16'h0037);
    run_one("min_rho", 16'h0000, 16'h8000, 16'h0100, 16'h0002);
    run_one("sat_pos", 16'h7FFF, 16'h7F00, 16'h7FFF, 16'h7FFF);
    run_one("sat_neg", 16'h8000, 16'h7F00, 16'h8000, 16'h8000);

    rst = 1'b1; step(); rst = 1'b0; step();
    exp_cnt = 0; lasts = 0;
    stream(8, 16'h0010, 0);

    rst = 1'b1; step(); rst = 1'b0; step();
    exp_cnt = 0; lasts = 0;
    stream(10, 16'h0200, 1);
    check("last_count", 32'(lasts), 32'd2);
    check("cnt_end", 32'(dut.cnt), 32'd2);

    out_ready = 1'b1;
    in_valid = 1'b1; in_mu = 16'h0300; in_rho = '0; in_eps = '0;
    step();
    in_mu = 16'h0301;
    step();
    in_mu = 16'h0302; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_mid_flush", 32'(out_valid), 32'd0);
    end
    exp_cnt = 0; lasts = 0;
    stream(4, 16'h0400, 0);
    check("rst_mid_last", 32'(lasts), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
